bit8_to_trit5: RTL and testbench

//  Converts one unsigned 8-bit value into five balanced-free base-3 digits (trits), 2-bit coded.

---
 rtl/ntru_trit_pkg.sv | 34 +++
 rtl/bit8_to_trit5_if.sv | 24 ++
 rtl/div3_u8.sv | 29 ++
 rtl/bit8_to_trit5.sv | 144 ++++++++++++++
 tb/tb_bit8_to_trit5.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/ntru_trit_pkg.sv
// Shared constants and types for the NTRU-HRSS byte -> trit unpacker.
// Trit coding: 00=0, 01=1, 11=2 (10 is never produced).
package ntru_trit_pkg;

  localparam int NTRIT = 5;
  localparam int BW    = 8;
  localparam int MAXV  = 3**NTRIT - 1;
  localparam logic [BW-1:0] MAXV_B = BW'(MAXV);

  localparam logic [1:0] TRIT_0 = 2'b00;
  localparam logic [1:0] TRIT_1 = 2'b01;
  localparam logic [1:0] TRIT_2 = 2'b11;

  typedef logic [1:0] trit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Map a binary remainder 0..2 onto the trit code; 3 cannot occur.
  function automatic trit_t enc_trit(input logic [1:0] r);
    trit_t t;
    case (r)
      2'd0:    t = TRIT_0;
      2'd1:    t = TRIT_1;
      2'd2:    t = TRIT_2;
      default: t = TRIT_0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bit8_to_trit5_if.sv
// Byte-in / trit-word-out valid/ready bundle for bit8_to_trit5.
// master = producer/consumer side, slave = converter.
interface bit8_to_trit5_if;
  import ntru_trit_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [BW-1:0]        in_byte;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*NTRIT-1:0]   out_trits;
  logic                 out_err;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_trits, out_err
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_trits, out_err
  );

endinterface

// File: rtl/div3_u8.sv
// Combinational unsigned divide-by-3: BW-bit quotient and 2-bit remainder,
// built as a restoring long division (running remainder never exceeds 2).
module div3_u8
  import ntru_trit_pkg::*;
(
  input  logic [BW-1:0] dividend,
  output logic [BW-1:0] quot,
  output logic [1:0]    rem
);

  logic [2:0] acc_s;

  // MSB-first long division by the constant 3
  always_comb begin
    acc_s = 3'd0;
    quot  = '0;
    for (int i = BW - 1; i >= 0; i--) begin
      acc_s = {acc_s[1:0], dividend[i]};
      if (acc_s >= 3'd3) begin
        quot[i] = 1'b1;
        acc_s   = acc_s - 3'd3;
      end else begin
        quot[i] = 1'b0;
      end
    end
    rem = acc_s[1:0];
  end

endmodule

// File: rtl/bit8_to_trit5.sv
// Iterative byte -> 5-trit converter, one divide-by-3 per clock, valid/ready both sides.
// Optional macro B2T_RANGE_CHECK_EN flags bytes above 242 via out_err and zeroes the trits.
module bit8_to_trit5
  import ntru_trit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  bit8_to_trit5_if.slave bus
);

  localparam int         TW       = 2 * NTRIT;
  localparam logic [2:0] LAST_CNT = 3'(NTRIT - 1);

  state_t          state_q, state_d;
  logic [2:0]      count_q, count_d;
  logic [BW-1:0]   v_q, v_d;
  logic [TW-1:0]   trits_q, trits_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [BW-1:0]   quot_s;
  logic [1:0]      rem_s;
  logic            accept_s;
  logic            last_step_s;
  logic            zero_trits_s;

  div3_u8 u_div3 (
    .dividend (v_q),
    .quot     (quot_s),
    .rem      (rem_s)
  );

  assign accept_s    = (state_q == IDLE) && bus.in_valid && in_ready_q;
  assign last_step_s = (state_q == CONV) && (count_q == LAST_CNT);

  // Next-state and datapath: remainders shift in from the top so digit 0 ends at [1:0]
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    v_d         = v_q;
    trits_d     = trits_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d    = CONV;
          v_d        = bus.in_byte;
          count_d    = 3'd0;
          in_ready_d = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      CONV: begin
        v_d = quot_s;
        if (last_step_s) begin
          state_d     = DONE;
          count_d     = 3'd0;
          out_valid_d = 1'b1;
          trits_d     = zero_trits_s ? '0 : {enc_trit(rem_s), trits_q[TW-1:2]};
        end else begin
          count_d = count_q + 3'd1;
          trits_d = {enc_trit(rem_s), trits_q[TW-1:2]};
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        count_d     = 3'd0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, counter, work and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 3'd0;
      v_q         <= '0;
      trits_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      v_q         <= v_d;
      trits_q     <= trits_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef B2T_RANGE_CHECK_EN
  logic range_q, range_d;
  logic err_q, err_d;

  // Out-of-range flag is taken at capture and exposed once the word completes
  always_comb begin
    range_d = range_q;
    err_d   = err_q;
    if (accept_s) begin
      range_d = (bus.in_byte > MAXV_B);
      err_d   = 1'b0;
    end else if (last_step_s) begin
      err_d = range_q;
    end else begin
      err_d = err_q;
    end
  end

  // Range-check registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      range_q <= range_d;
      err_q   <= err_d;
    end
  end

  assign zero_trits_s = range_q;
  assign bus.out_err  = err_q;
`else
  assign zero_trits_s = 1'b0;
  assign bus.out_err  = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_trits = trits_q;

endmodule

// File: tb/tb_bit8_to_trit5.sv
// Randomized self-checking bench for bit8_to_trit5 against a plain base-3 reference.
// Honours B2T_RANGE_CHECK_EN the same way the design does.
module tb_bit8_to_trit5;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bit8_to_trit5_if bus ();

  bit8_to_trit5 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: five least-significant base-3 digits, digit i in bits [2i+1:2i]
  function automatic logic [9:0] ref_trits(input int b);
    logic [9:0] r;
    int x;
    r = 10'd0;
    x = b;
`ifdef B2T_RANGE_CHECK_EN
    if (b > 242) x = 0;
`endif
    for (int i = 0; i < 5; i++) begin
      case (x % 3)
        0:       r[2*i +: 2] = 2'b00;
        1:       r[2*i +: 2] = 2'b01;
        default: r[2*i +: 2] = 2'b11;
      endcase
      x = x / 3;
    end
    return r;
  endfunction

  function automatic logic ref_err(input int b);
`ifdef B2T_RANGE_CHECK_EN
    return (b > 242);
`else
    return (b < 0);
`endif
  endfunction

  task automatic convert(input logic [7:0] b, input logic [9:0] exp_t, input logic exp_e,
                         input int hold);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(negedge clk);
    check_eq("in_ready_busy", 32'(bus.in_ready), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      bus.in_valid = 1'($urandom);
      bus.in_byte  = 8'($urandom);
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check_eq("latency", 32'(n), 32'd5);
    check_eq("trits", 32'(bus.out_trits), 32'(exp_t));
    check_eq("err", 32'(bus.out_err), 32'(exp_e));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_trits", 32'(bus.out_trits), 32'(exp_t));
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("valid_drop", 32'(bus.out_valid), 32'd0);
    check_eq("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] rb;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_trits", 32'(bus.out_trits), 32'd0);
    check_eq("rst_out_err", 32'(bus.out_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    convert(8'd0,   10'h000, 1'b0, 0);
    convert(8'd242, 10'h3FF, 1'b0, 1);
    convert(8'd100, 10'h131, 1'b0, 10);
`ifdef B2T_RANGE_CHECK_EN
    convert(8'd255, 10'h000, 1'b1, 2);
`else
    convert(8'd255, 10'h014, 1'b0, 2);
`endif

    // Reset after two conversion steps abandons the byte
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'd100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    convert(8'd7, ref_trits(7), ref_err(7), 0);

    for (int b = 0; b <= 242; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      convert(8'(b), ref_trits(b), ref_err(b), int'($urandom_range(0, 3)));
    end

    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      convert(rb, ref_trits(int'(rb)), ref_err(int'(rb)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
